// File: rtl/phys_reg_file_mp_pkg.sv
// Shared sizes and types for the multi-port physical register file.
package phys_reg_file_mp_pkg;

   localparam int unsigned NUM_PREGS = 64;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned PREG_W    = $clog2(NUM_PREGS);

   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [XLEN-1:0]   word_t;

   localparam preg_t PREG_ZERO = '0;

endpackage

// File: rtl/phys_reg_file_mp_if.sv
// Reg-read / writeback / rename bundle for the physical register file, one array slot per port.
interface phys_reg_file_mp_if
   import phys_reg_file_mp_pkg::*;
#(
   parameter int unsigned NUM_RD    = 4,
   parameter int unsigned NUM_WR    = 2,
   parameter int unsigned NUM_ALLOC = 2,
   parameter int unsigned NUM_RQ    = 4
);

   logic                          flush;
   logic  [NUM_RD-1:0]            rd_en;
   preg_t [NUM_RD-1:0]            rd_preg;
   logic  [NUM_RD-1:0]            rd_vld;
   word_t [NUM_RD-1:0]            rd_data;
   logic  [NUM_WR-1:0]            wr_en;
   preg_t [NUM_WR-1:0]            wr_preg;
   word_t [NUM_WR-1:0]            wr_data;
   logic  [NUM_ALLOC-1:0]         alloc_en;
   preg_t [NUM_ALLOC-1:0]         alloc_preg;
   preg_t [NUM_RQ-1:0]            rq_preg;
   logic  [NUM_RQ-1:0]            rq_rdy;

   modport master (
      output flush, rd_en, rd_preg, wr_en, wr_preg, wr_data, alloc_en, alloc_preg, rq_preg,
      input  rd_vld, rd_data, rq_rdy
   );

   modport slave (
      input  flush, rd_en, rd_preg, wr_en, wr_preg, wr_data, alloc_en, alloc_preg, rq_preg,
      output rd_vld, rd_data, rq_rdy
   );

endinterface

// File: rtl/phys_reg_file_mp_prf_ready_table.sv
// Per-preg ready bits: writeback sets, rename allocation clears (alloc wins), queries see old state.
module prf_ready_table
   import phys_reg_file_mp_pkg::*;
#(
   parameter int unsigned NUM_PREGS = phys_reg_file_mp_pkg::NUM_PREGS,
   parameter int unsigned NUM_ALLOC = 2,
   parameter int unsigned NUM_WR    = 2,
   parameter int unsigned NUM_RQ    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic  [NUM_WR-1:0]    wr_en_i,
   input  preg_t [NUM_WR-1:0]    wr_preg_i,
   input  logic  [NUM_ALLOC-1:0] alloc_en_i,
   input  preg_t [NUM_ALLOC-1:0] alloc_preg_i,
   input  preg_t [NUM_RQ-1:0]    rq_preg_i,
   output logic  [NUM_RQ-1:0]    rq_rdy_o
);

   logic [NUM_PREGS-1:0] ready_q, ready_d;

   // Clears applied after sets so a same-cycle alloc leaves the bit at 0.
   always_comb begin
      ready_d = ready_q;
      for (int j = 0; j < int'(NUM_WR); j++) begin
         if (wr_en_i[j] && wr_preg_i[j] != PREG_ZERO) ready_d[wr_preg_i[j]] = 1'b1;
      end
      for (int k = 0; k < int'(NUM_ALLOC); k++) begin
         if (alloc_en_i[k] && alloc_preg_i[k] != PREG_ZERO) ready_d[alloc_preg_i[k]] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ready_q <= '1;
      else        ready_q <= ready_d;
   end

   always_comb begin
      rq_rdy_o = '0;
      for (int q = 0; q < int'(NUM_RQ); q++) rq_rdy_o[q] = ready_q[rq_preg_i[q]];
   end

endmodule

// File: rtl/phys_reg_file_mp.sv
// Multi-port physical register file with registered reads and a ready table.
// Define PRF_WB_BYPASS_EN to forward same-cycle writeback data into reads.
module phys_reg_file_mp
   import phys_reg_file_mp_pkg::*;
#(
   parameter int unsigned NUM_RD    = 4,
   parameter int unsigned NUM_WR    = 2,
   parameter int unsigned NUM_ALLOC = 2,
   parameter int unsigned NUM_RQ    = 4
) (
   input logic               clk,
   input logic               rst_n,
   phys_reg_file_mp_if.slave prf_if
);

   localparam int unsigned PW = PREG_W;

   word_t prf_q [NUM_PREGS];
   word_t prf_d [NUM_PREGS];

   logic  [NUM_RD-1:0] rd_vld_q, rd_vld_d;
   word_t [NUM_RD-1:0] rd_data_q, rd_data_d;

   // Ascending port order makes the highest-index writer win.
   always_comb begin
      prf_d = prf_q;
      for (int j = 0; j < int'(NUM_WR); j++) begin
         if (prf_if.wr_en[j] && prf_if.wr_preg[j] != PREG_ZERO) begin
            prf_d[prf_if.wr_preg[j]] = prf_if.wr_data[j];
         end
      end
   end

   always_comb begin
      rd_vld_d  = prf_if.rd_en & ~{NUM_RD{prf_if.flush}};
      rd_data_d = rd_data_q;
      for (int i = 0; i < int'(NUM_RD); i++) begin
         if (rd_vld_d[i]) begin
            rd_data_d[i] = prf_q[prf_if.rd_preg[i]];
`ifdef PRF_WB_BYPASS_EN
            for (int j = 0; j < int'(NUM_WR); j++) begin
               if (prf_if.wr_en[j] && prf_if.wr_preg[j] == prf_if.rd_preg[i]) begin
                  rd_data_d[i] = prf_if.wr_data[j];
               end
            end
`endif
            if (prf_if.rd_preg[i] == PREG_ZERO) rd_data_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int p = 0; p < int'(NUM_PREGS); p++) prf_q[p] <= '0;
         rd_vld_q  <= '0;
         rd_data_q <= '0;
      end else begin
         prf_q     <= prf_d;
         rd_vld_q  <= rd_vld_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign prf_if.rd_vld  = rd_vld_q;
   assign prf_if.rd_data = rd_data_q;

   prf_ready_table #(
      .NUM_PREGS (NUM_PREGS),
      .NUM_ALLOC (NUM_ALLOC),
      .NUM_WR    (NUM_WR),
      .NUM_RQ    (NUM_RQ)
   ) u_ready_table (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en_i      (prf_if.wr_en),
      .wr_preg_i    (prf_if.wr_preg),
      .alloc_en_i   (prf_if.alloc_en),
      .alloc_preg_i (prf_if.alloc_preg),
      .rq_preg_i    (prf_if.rq_preg),
      .rq_rdy_o     (prf_if.rq_rdy)
   );

   // Two writeback ports targeting the same non-zero preg is an upstream bug.
   for (genvar a = 0; a < int'(NUM_WR); a++) begin : g_wr_a
      for (genvar b = a + 1; b < int'(NUM_WR); b++) begin : g_wr_b
         a_no_dup_wr : assert property (@(posedge clk) disable iff (!rst_n)
            !(prf_if.wr_en[a] && prf_if.wr_en[b] && prf_if.wr_preg[a] == prf_if.wr_preg[b]
              && prf_if.wr_preg[a] != PREG_ZERO));
      end
   end

   logic [PW-1:0] unused_pw;
   assign unused_pw = '0;

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Directed bench for phys_reg_file_mp; expectations follow PRF_WB_BYPASS_EN when defined.
module tb_phys_reg_file_mp;
   import phys_reg_file_mp_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   phys_reg_file_mp_if #(.NUM_RD(4), .NUM_WR(2), .NUM_ALLOC(2), .NUM_RQ(4)) prf_if ();

   phys_reg_file_mp #(.NUM_RD(4), .NUM_WR(2), .NUM_ALLOC(2), .NUM_RQ(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .prf_if (prf_if.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      prf_if.flush      = 1'b0;
      prf_if.rd_en      = '0;
      prf_if.rd_preg    = '0;
      prf_if.wr_en      = '0;
      prf_if.wr_preg    = '0;
      prf_if.wr_data    = '0;
      prf_if.alloc_en   = '0;
      prf_if.alloc_preg = '0;
      prf_if.rq_preg    = '0;
   endtask

   // Advance one edge and settle past it; inputs are then safe to change.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int port, input int preg);
      prf_if.rd_en[port]   = 1'b1;
      prf_if.rd_preg[port] = preg_t'(preg);
   endtask

   task automatic wr(input int port, input int preg, input logic [31:0] data);
      prf_if.wr_en[port]   = 1'b1;
      prf_if.wr_preg[port] = preg_t'(preg);
      prf_if.wr_data[port] = data;
   endtask

   logic [31:0] exp_same_cycle;

   initial begin
`ifdef PRF_WB_BYPASS_EN
      exp_same_cycle = 32'h0000_1234;
`else
      exp_same_cycle = 32'h0000_0000;
`endif
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      check_eq("reset_rd_vld", 32'(prf_if.rd_vld), 32'h0);
      check_eq("reset_rd_data0", prf_if.rd_data[0], 32'h0);
      prf_if.rq_preg[0] = 6'd5;
      prf_if.rq_preg[1] = 6'd7;
      prf_if.rq_preg[2] = 6'd12;
      prf_if.rq_preg[3] = 6'd63;
      #1;
      check_eq("reset_rq_rdy", 32'(prf_if.rq_rdy), 32'hF);
      rst_n = 1'b1;
      tick();

      // 1: all ports read preg 5
      idle();
      for (int i = 0; i < 4; i++) rd(i, 5);
      prf_if.rq_preg[0] = 6'd5;
      tick();
      check_eq("t1_rd_vld", 32'(prf_if.rd_vld), 32'hF);
      for (int i = 0; i < 4; i++) check_eq($sformatf("t1_rd_data%0d", i), prf_if.rd_data[i], 32'h0);
      check_eq("t1_rq_rdy5", 32'(prf_if.rq_rdy[0]), 32'h1);

      // 2: write then read preg 7
      idle();
      wr(0, 7, 32'hDEAD_BEEF);
      tick();
      idle();
      rd(2, 7);
      prf_if.rq_preg[1] = 6'd7;
      tick();
      check_eq("t2_rd_vld", 32'(prf_if.rd_vld), 32'h4);
      check_eq("t2_rd_data", prf_if.rd_data[2], 32'hDEAD_BEEF);
      check_eq("t2_rq_rdy7", 32'(prf_if.rq_rdy[1]), 32'h1);

      // rd_en low: valid drops, data holds
      idle();
      tick();
      check_eq("hold_rd_vld", 32'(prf_if.rd_vld), 32'h0);
      check_eq("hold_rd_data", prf_if.rd_data[2], 32'hDEAD_BEEF);

      // 3: same-cycle write/read preg 9, with preg 9 read on port 3 the cycle after
      idle();
      wr(1, 9, 32'h0000_1234);
      rd(1, 9);
      tick();
      check_eq("t3_same_cycle", prf_if.rd_data[1], exp_same_cycle);
      idle();
      rd(3, 9);
      tick();
      check_eq("t3_next_cycle", prf_if.rd_data[3], 32'h0000_1234);

      // Two ports writing distinct pregs in one cycle
      idle();
      wr(0, 20, 32'hA5A5_0001);
      wr(1, 21, 32'h5A5A_0002);
      tick();
      idle();
      rd(0, 20);
      rd(1, 21);
      rd(2, 63);
      tick();
      check_eq("dual_wr_p20", prf_if.rd_data[0], 32'hA5A5_0001);
      check_eq("dual_wr_p21", prf_if.rd_data[1], 32'h5A5A_0002);
      check_eq("unwritten_p63", prf_if.rd_data[2], 32'h0);

      // 4: writes to preg 0 are dropped
      idle();
      wr(0, 0, 32'hFFFF_FFFF);
      rd(0, 7);
      tick();
      idle();
      rd(0, 0);
      prf_if.rq_preg[0] = 6'd0;
      tick();
      check_eq("t4_preg0", prf_if.rd_data[0], 32'h0);
      check_eq("t4_rq_rdy0", 32'(prf_if.rq_rdy[0]), 32'h1);

      // 5: alloc clears, write sets, alloc beats same-cycle write
      idle();
      prf_if.alloc_en[1]   = 1'b1;
      prf_if.alloc_preg[1] = 6'd12;
      prf_if.rq_preg[2]    = 6'd12;
      #1;
      check_eq("t5_rq_pre_alloc", 32'(prf_if.rq_rdy[2]), 32'h1);
      tick();
      check_eq("t5_rq_after_alloc", 32'(prf_if.rq_rdy[2]), 32'h0);
      idle();
      prf_if.rq_preg[2] = 6'd12;
      wr(0, 12, 32'h0000_0055);
      #1;
      check_eq("t5_rq_pre_wr", 32'(prf_if.rq_rdy[2]), 32'h0);
      tick();
      check_eq("t5_rq_after_wr", 32'(prf_if.rq_rdy[2]), 32'h1);
      idle();
      prf_if.rq_preg[2]    = 6'd12;
      prf_if.alloc_en[0]   = 1'b1;
      prf_if.alloc_preg[0] = 6'd12;
      wr(1, 12, 32'h0000_0066);
      rd(0, 12);
      tick();
      check_eq("t5_alloc_wins", 32'(prf_if.rq_rdy[2]), 32'h0);
      idle();
      rd(0, 12);
      tick();
      check_eq("t5_data_written", prf_if.rd_data[0], 32'h0000_0066);

      // 6: flush kills the read, contents survive
      idle();
      rd(0, 7);
      rd(3, 7);
      prf_if.flush = 1'b1;
      tick();
      check_eq("t6_flush_vld", 32'(prf_if.rd_vld), 32'h0);
      idle();
      rd(1, 7);
      tick();
      check_eq("t6_after_flush", prf_if.rd_data[1], 32'hDEAD_BEEF);

      // Reset with a read in flight
      idle();
      rd(0, 7);
      rst_n = 1'b0;
      tick();
      check_eq("t6_rst_vld", 32'(prf_if.rd_vld), 32'h0);
      check_eq("t6_rst_data", prf_if.rd_data[1], 32'h0);
      rst_n = 1'b1;
      idle();
      rd(0, 7);
      prf_if.rq_preg[0] = 6'd12;
      tick();
      check_eq("t6_post_rst_vld", 32'(prf_if.rd_vld), 32'h1);
      check_eq("t6_post_rst_p7", prf_if.rd_data[0], 32'h0);
      check_eq("t6_post_rst_rq12", 32'(prf_if.rq_rdy[0]), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
